// File: rtl/fmap_pixel_streamer.sv
// Streams one 8-bit feature-map channel from activation SRAM to the convolutor, with column padding flags.
// Optional vertical zero-padding rows are enabled by defining ZERO_PAD_ROWS_EN.
module fmap_pixel_streamer #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int ADDR_W       = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [7:0]               width,
    input  logic [7:0]               height,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [7:0]               mem_rdata,
    output logic signed [7:0]        pixel_out,
    output logic                     pixel_valid,
    input  logic                     pixel_ready,
    output logic                     paddingl,
    output logic                     paddingr,
    output logic                     last,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

    localparam logic [8:0] MAX_W = 9'(IMAGE_WIDTH);
    localparam logic [8:0] MAX_H = 9'(IMAGE_HEIGHT);

    state_t              state, state_nxt;
    logic [7:0]          w_r, h_r;
    logic [ADDR_W-1:0]   addr;
    logic [7:0]          rc;
    logic [8:0]          rr, rr_last;
    logic                is_pad, col_last, row_last, issue, push, pop;
    logic [1:0]          count, count_nxt;
    logic [2:0]          occ;
    logic                vld_p1, pad_p1, pl_p1, pr_p1, last_p1;
    logic [10:0]         in_ent, head, tail;

    function automatic logic signed [7:0] stage_pixel(input logic pad, input logic [7:0] raw);
        return pad ? 8'sd0 : signed'(raw);
    endfunction

`ifdef ZERO_PAD_ROWS_EN
    // Row 0 and row height+1 are synthetic zero rows that never touch the SRAM.
    assign rr_last = {1'b0, h_r} + 9'd1;
    assign is_pad  = (rr == 9'd0) || (rr == rr_last);
`else
    assign rr_last = {1'b0, h_r} - 9'd1;
    assign is_pad  = 1'b0;
`endif

    assign col_last    = (rc == w_r - 8'd1);
    assign row_last    = (rr == rr_last);
    assign pixel_valid = (count != 2'd0);
    assign pop         = pixel_valid && pixel_ready;
    assign push        = vld_p1;
    assign count_nxt   = count + {1'b0, push} - {1'b0, pop};
    // Credit the pop of this cycle so a full pipe still sustains one pixel per clock.
    assign occ         = {1'b0, count} + {2'b0, vld_p1} - {2'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (width == 8'd0 || height == 8'd0) ? FINISH : STREAM;
            STREAM:  if (issue && col_last && row_last) state_nxt = DRAIN;
            DRAIN:   if (count_nxt == 2'd0) state_nxt = FINISH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == STREAM) || (state == DRAIN);
        done      = (state == FINISH);
        issue     = (state == STREAM) && (occ < 3'd2);
        mem_rd_en = issue && !is_pad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_r  <= '0;
            h_r  <= '0;
            addr <= '0;
            rc   <= '0;
            rr   <= '0;
        end else if (state == IDLE && start) begin
            w_r  <= ({1'b0, width}  > MAX_W) ? MAX_W[7:0] : width;
            h_r  <= ({1'b0, height} > MAX_H) ? MAX_H[7:0] : height;
            addr <= base_addr;
            rc   <= '0;
            rr   <= '0;
        end else if (issue) begin
            if (!is_pad) addr <= addr + ADDR_W'(1);
            if (col_last) begin
                rc <= '0;
                rr <= rr + 9'd1;
            end else begin
                rc <= rc + 8'd1;
            end
        end
    end

    assign mem_addr = addr;

    // p1: read in flight; flags ride alongside until SRAM data returns.
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= issue;
    end

    always_ff @(posedge clk) begin
        pad_p1  <= is_pad;
        pl_p1   <= (rc == 8'd0);
        pr_p1   <= col_last;
        last_p1 <= col_last && row_last;
    end

    // p2: two-entry output buffer, head entry drives the outputs.
    assign in_ent = {stage_pixel(pad_p1, mem_rdata), pl_p1, pr_p1, last_p1};

    always_ff @(posedge clk) begin
        if (rst) count <= 2'd0;
        else     count <= count_nxt;
    end

    always_ff @(posedge clk) begin
        case (count)
            2'd0: if (push) head <= in_ent;
            2'd1: begin
                if (push && pop) head <= in_ent;
                else if (push)   tail <= in_ent;
            end
            default: begin
                if (pop) begin
                    head <= tail;
                    if (push) tail <= in_ent;
                end
            end
        endcase
    end

    assign pixel_out = pixel_valid ? signed'(head[10:3]) : 8'sd0;
    assign paddingl  = pixel_valid && head[2];
    assign paddingr  = pixel_valid && head[1];
    assign last      = pixel_valid && head[0];

endmodule

// File: tb/tb_fmap_pixel_streamer.sv
// Directed bench for fmap_pixel_streamer: SRAM model, handshake monitor, per-frame scoreboard.
module tb_fmap_pixel_streamer;
    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         width = '0;
    logic [7:0]         height = '0;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_rdata = '0;
    logic signed [7:0]  pixel_out;
    logic               pixel_valid;
    logic               pixel_ready = 1'b1;
    logic               paddingl, paddingr, last, busy, done;

    logic [7:0] sram [0:DEPTH-1];
    int nvec = 0, nerr = 0, cyc = 0, rmode = 0;
    int rd_n = 0, hs_n = 0, done_n = 0, done_cyc = -1, start_cyc = -1, first_v = -1;
    int q_pix[$];
    int q_cyc[$];
    logic        stall_prev = 1'b0;
    logic [11:0] held = '0;

    always #5 clk = ~clk;

    fmap_pixel_streamer #(.IMAGE_WIDTH(128), .IMAGE_HEIGHT(128), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
        .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .paddingl(paddingl), .paddingr(paddingr),
        .last(last), .busy(busy), .done(done)
    );

    initial for (int i = 0; i < DEPTH; i++) sram[i] = 8'(i - 16);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rdata <= sram[mem_addr];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 pixel_ready = (rmode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
    end

    always @(negedge clk) begin
        logic [11:0] cur;
        cur = {pixel_valid, pixel_out, paddingl, paddingr, last};
        if (!rst) begin
            if (mem_rd_en) rd_n++;
            if (pixel_valid && pixel_ready) begin
                q_pix.push_back(int'({pixel_out, paddingl, paddingr, last}));
                q_cyc.push_back(cyc);
                hs_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (pixel_valid && first_v < 0) first_v = cyc;
            if (start && !busy && !done && start_cyc < 0) start_cyc = cyc;
            if (stall_prev) chk("stall_hold", int'(cur), int'(held));
            if (busy) chk("occupancy", int'(rd_n - hs_n <= 2), 1);
            stall_prev = pixel_valid && !pixel_ready;
            held = cur;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic int n_pix(input int w, input int h);
        if (w == 0 || h == 0) return 0;
`ifdef ZERO_PAD_ROWS_EN
        return (h + 2) * w;
`else
        return w * h;
`endif
    endfunction

    function automatic int exp_ent(input int i, input int w, input int h, input int base);
        int row, col, n, pix;
        row = i / w;
        col = i % w;
        n   = n_pix(w, h);
`ifdef ZERO_PAD_ROWS_EN
        if (row == 0 || row == h + 1) pix = 0;
        else pix = (((base + (row - 1) * w + col) % DEPTH) - 16) & 255;
`else
        pix = (((base + i) % DEPTH) - 16) & 255;
`endif
        return (pix << 3) | (int'(col == 0) << 2) | (int'(col == w - 1) << 1) | int'(i == n - 1);
    endfunction

    task automatic clear_counts();
        q_pix.delete();
        q_cyc.delete();
        rd_n = 0; hs_n = 0; done_n = 0;
        done_cyc = -1; start_cyc = -1; first_v = -1;
    endtask

    task automatic pulse_start(input int w, input int h, input int base);
        @(posedge clk);
        #1 width = 8'(w); height = 8'(h); base_addr = ADDR_W'(base); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int base,
                             input int mode, input bit restart);
        int n, m;
        rmode = mode;
        clear_counts();
        pulse_start(w, h, base);
        if (w != 0 && h != 0) chk({tag, "_busy"}, int'(busy), 1);
        if (restart) begin
            repeat (3) @(posedge clk);
            #1 width = 8'd2; height = 8'd1; base_addr = '0; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int k = 0; k < 400 && done_n == 0; k++) @(negedge clk);
        chk({tag, "_done_seen"}, int'(done_n > 0), 1);
        repeat (3) @(negedge clk);
        n = n_pix(w, h);
        m = (q_pix.size() < n) ? q_pix.size() : n;
        chk({tag, "_count"}, q_pix.size(), n);
        chk({tag, "_reads"}, rd_n, w * h);
        chk({tag, "_done_once"}, done_n, 1);
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_px%0d", tag, i), q_pix[i], exp_ent(i, w, h, base));
        if (n > 0) begin
            chk({tag, "_latency"}, first_v - start_cyc, 3);
            if (m == n) chk({tag, "_done_lat"}, done_cyc - q_cyc[n-1], 1);
            if (mode == 0 && m == n) chk({tag, "_burst"}, q_cyc[n-1] - q_cyc[0], n - 1);
        end else begin
            chk({tag, "_done_lat"}, done_cyc - start_cyc, 1);
        end
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, int'(pixel_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_pixel"}, int'(pixel_out), 0);
        chk({tag, "_flags"}, int'({paddingl, paddingr, last}), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        rst = 1'b0;

        run_frame("basic", 4, 3, 16, 0, 1'b0);
        run_frame("bp", 4, 3, 16, 1, 1'b0);
        run_frame("w1", 1, 2, 16, 0, 1'b0);
        run_frame("w0", 0, 3, 16, 0, 1'b0);

        rmode = 0;
        clear_counts();
        pulse_start(4, 3, 16);
        for (int k = 0; k < 100 && hs_n < 5; k++) @(negedge clk);
        chk("abort_progress", int'(hs_n >= 5), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        done_n = 0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", done_n, 0);
        run_frame("after_rst", 4, 3, 16, 0, 1'b0);

        run_frame("restart", 4, 3, 16, 0, 1'b1);
        run_frame("wrap", 4, 1, DEPTH - 2, 0, 1'b0);
`ifdef ZERO_PAD_ROWS_EN
        run_frame("pad", 3, 2, 16, 0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
